anim_sequencer: RTL and testbench
=================================

Name: anim_sequencer

Overview:
Control sequencer for the seven-segment animation datapath. It takes the four debounced button levels and an autoplay toggle, and arbitrates their step requests plus an autoplay advance onto one shared update port. It drives the animation index and speed compare value into the counter/seg7 datapath. Held buttons auto-repeat, and autoplay advances the animation after a programmable number of frame wraps.

Parameters:
ANI_BIT, 6, width of animation index; maximum index is 2^ANI_BIT-1
CMP_BIT, 25, width of compare value
CMP_DEFAULT, 10_000_000, compare value at reset (1 s at 10 MHz)
CMP_MIN, 1_000_000, lowest legal compare value
CMP_MAX, 19_000_000, highest legal compare value
CMP_STEP, 1_000_000, compare step per speed request
REPEAT_BIT, 24, width of each hold/repeat counter
REPEAT_VAL, 5_000_000, hold cycles before each auto-repeat request
DWELL_BIT, 4, width of dwell count and dwell_i

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
btn_next_i  in  1  debounced level: next animation
btn_prev_i  in  1  debounced level: previous animation
btn_fast_i  in  1  debounced level: faster (compare minus step)
btn_slow_i  in  1  debounced level: slower (compare plus step)
btn_auto_i  in  1  debounced level: each rising edge toggles autoplay
frame_wrap_i  in  1  one-cycle pulse when the datapath digit wraps to 0
dwell_i  in  DWELL_BIT  frame wraps per animation in autoplay; 0 is treated as 1
animation_o  out  ANI_BIT  current animation index
compare_o  out  CMP_BIT  current speed compare value
auto_o  out  1  autoplay active
ani_changed_o  out  1  one-cycle pulse, high in the same cycle a new animation_o value first appears

Behaviour:
- Reset (asynchronous, active-high) values:
  - animation_o=0, compare_o=CMP_DEFAULT, auto_o=0, ani_changed_o=0.
  - All pending bits, repeat counters, dwell counter and button history registers are 0.
  - A button held through reset release therefore registers as a rising edge in the first cycle after release.
- Request generation, for each of next/prev/fast/slow:
  - A request fires on a rising edge (level=1 and history=0).
  - While the level stays 1, the repeat counter increments each cycle. When it reaches REPEAT_VAL-1, a request fires and the counter returns to 0.
  - Level=0 clears the counter.
- Pending register:
  - Five bits: P_NEXT, P_PREV, P_FAST, P_SLOW, P_AUTO.
  - A request sets its bit at the next clock edge.
  - A request arriving while its bit is already set merges into it; requests are not counted.
- Arbiter:
  - Fixed priority, highest first: P_NEXT > P_PREV > P_FAST > P_SLOW > P_AUTO.
  - The grant is combinational from the pending bits; at most one grant per cycle.
  - At the clock edge the granted bit clears and the granted action updates the outputs.
  - A bit that is both granted and re-requested in the same cycle stays set.
- Latency: button rising edge sampled at edge n, pending set at edge n+1, output updated at edge n+2 when nothing of higher priority is pending.
- Actions:
  - NEXT, and AUTO: animation+1; at 2^ANI_BIT-1 it wraps to 0.
  - PREV: animation-1; at 0 it wraps to 2^ANI_BIT-1.
  - FAST: if compare >= CMP_MIN+CMP_STEP then compare-CMP_STEP, else unchanged (saturate).
  - SLOW: if compare+CMP_STEP <= CMP_MAX then compare+CMP_STEP, else unchanged (saturate).
  - A saturated grant is still consumed.
  - ani_changed_o is registered: 1 for exactly the one cycle following any NEXT/PREV/AUTO grant, otherwise 0.
- Autoplay:
  - A rising edge of btn_auto_i toggles auto_o at the next edge.
  - While auto_o=1, each frame_wrap_i increments the dwell counter.
  - When the count would reach max(dwell_i,1), P_AUTO is set and the counter returns to 0.
  - A NEXT or PREV grant clears the dwell counter, so a manual step restarts the dwell.
  - Leaving autoplay clears the dwell counter and P_AUTO in the same edge.
  - frame_wrap_i is ignored while auto_o=0.
  - If a dwell_i change leaves the counter already ≥ max(dwell_i,1), the next frame_wrap_i sets P_AUTO.
- Simultaneous events: all five pending bits may be set at once; they are served in priority order, one per cycle, over consecutive cycles.
- Reset mid-operation discards all pending requests; no output change is emitted after release except those caused by a subsequent edge.

Test Plan:
- Reset, then pulse btn_next_i high for 3 cycles -> animation_o 0→1 exactly 2 cycles after the rise; ani_changed_o high for 1 cycle; compare_o=10_000_000.
- From animation 0, rise btn_prev_i -> animation_o=63. Then from 63, rise btn_next_i -> animation_o=0 (both wraps).
- Raise next, prev, fast and slow in the same cycle with compare=10_000_000 -> consecutive cycles show animation 1, animation 0, compare 9_000_000, compare 10_000_000.
- Hold btn_fast_i with REPEAT_VAL=8 from compare=3_000_000 -> compare steps to 2_000_000, then 1_000_000 after 8 more cycles, then stays 1_000_000 (saturated). Repeat for slow saturating at 19_000_000.
- Toggle auto on, dwell_i=3, send frame_wrap_i pulses -> animation advances on every 3rd pulse. Press next after 2 pulses -> animation +1 and the dwell count restarts (3 more pulses needed). dwell_i=0 -> advance on every pulse.
- Assert reset with all pending bits set and auto_o=1 -> all outputs at reset values. Keep btn_next_i high across reset release -> one step to animation 1.

Source files
------------

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - button/autoplay request arbiter driving animation index and speed compare value
// Each button raises a request on its rising edge and again on auto-repeat; one grant is served per cycle.
module anim_sequencer #(
  parameter int ANI_BIT     = 6,
  parameter int CMP_BIT     = 25,
  parameter int CMP_DEFAULT = 10_000_000,
  parameter int CMP_MIN     = 1_000_000,
  parameter int CMP_MAX     = 19_000_000,
  parameter int CMP_STEP    = 1_000_000,
  parameter int REPEAT_BIT  = 24,
  parameter int REPEAT_VAL  = 5_000_000,
  parameter int DWELL_BIT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next_i,
  input  logic                 btn_prev_i,
  input  logic                 btn_fast_i,
  input  logic                 btn_slow_i,
  input  logic                 btn_auto_i,
  input  logic                 frame_wrap_i,
  input  logic [DWELL_BIT-1:0] dwell_i,
  output logic [ANI_BIT-1:0]   animation_o,
  output logic [CMP_BIT-1:0]   compare_o,
  output logic                 auto_o,
  output logic                 ani_changed_o
);

  localparam int P_NEXT = 0;
  localparam int P_PREV = 1;
  localparam int P_FAST = 2;
  localparam int P_SLOW = 3;
  localparam int P_AUTO = 4;

  localparam logic [CMP_BIT:0]    FAST_LIM = (CMP_BIT+1)'(CMP_MIN + CMP_STEP);
  localparam logic [CMP_BIT:0]    CMP_TOP  = (CMP_BIT+1)'(CMP_MAX);
  localparam logic [CMP_BIT:0]    STEP_W   = (CMP_BIT+1)'(CMP_STEP);
  localparam logic [REPEAT_BIT-1:0] RPT_LAST = REPEAT_BIT'(REPEAT_VAL - 1);

  logic [4:0]            lvl, rise;
  logic [4:0]            hist_q;
  logic [REPEAT_BIT-1:0] rpt_q [4];
  logic [REPEAT_BIT-1:0] rpt_d [4];
  logic [3:0]            req;
  logic [4:0]            pend_q, pend_d, grant;
  logic [DWELL_BIT-1:0]  dwell_q, dwell_d;
  logic [DWELL_BIT:0]    dwell_inc, dwell_lim;
  logic [ANI_BIT-1:0]    ani_q, ani_d;
  logic [CMP_BIT-1:0]    cmp_q, cmp_d;
  logic                  auto_q, auto_d, chg_q, chg_d;

  assign lvl  = {btn_auto_i, btn_slow_i, btn_fast_i, btn_prev_i, btn_next_i};
  assign rise = lvl & ~hist_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rpt_d[i] = rpt_q[i];
      req[i]   = rise[i];
      if (!lvl[i]) begin
        rpt_d[i] = '0;
      end else if (rpt_q[i] == RPT_LAST) begin
        req[i]   = 1'b1;
        rpt_d[i] = '0;
      end else begin
        rpt_d[i] = rpt_q[i] + REPEAT_BIT'(1);
      end
    end
  end

  always_comb begin
    grant = '0;
    if      (pend_q[P_NEXT]) grant[P_NEXT] = 1'b1;
    else if (pend_q[P_PREV]) grant[P_PREV] = 1'b1;
    else if (pend_q[P_FAST]) grant[P_FAST] = 1'b1;
    else if (pend_q[P_SLOW]) grant[P_SLOW] = 1'b1;
    else if (pend_q[P_AUTO]) grant[P_AUTO] = 1'b1;
  end

  assign dwell_inc = {1'b0, dwell_q} + (DWELL_BIT+1)'(1);
  assign dwell_lim = (dwell_i == '0) ? (DWELL_BIT+1)'(1) : {1'b0, dwell_i};

  // >= rather than == so a shrunken dwell_i still fires on the next wrap
  always_comb begin
    pend_d  = (pend_q & ~grant) | {1'b0, req};
    dwell_d = dwell_q;
    auto_d  = auto_q ^ rise[P_AUTO];
    if (auto_q && rise[P_AUTO]) begin
      dwell_d        = '0;
      pend_d[P_AUTO] = 1'b0;
    end else if (grant[P_NEXT] || grant[P_PREV]) begin
      dwell_d = '0;
    end else if (auto_q && frame_wrap_i) begin
      if (dwell_inc >= dwell_lim) begin
        pend_d[P_AUTO] = 1'b1;
        dwell_d        = '0;
      end else begin
        dwell_d = dwell_inc[DWELL_BIT-1:0];
      end
    end
  end

  always_comb begin
    ani_d = ani_q;
    cmp_d = cmp_q;
    chg_d = grant[P_NEXT] | grant[P_PREV] | grant[P_AUTO];
    if (grant[P_NEXT] || grant[P_AUTO]) ani_d = ani_q + ANI_BIT'(1);
    if (grant[P_PREV])                  ani_d = ani_q - ANI_BIT'(1);
    if (grant[P_FAST] && ({1'b0, cmp_q} >= FAST_LIM))
      cmp_d = cmp_q - CMP_BIT'(CMP_STEP);
    if (grant[P_SLOW] && (({1'b0, cmp_q} + STEP_W) <= CMP_TOP))
      cmp_d = cmp_q + CMP_BIT'(CMP_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      pend_q  <= '0;
      dwell_q <= '0;
      ani_q   <= '0;
      cmp_q   <= CMP_BIT'(CMP_DEFAULT);
      auto_q  <= 1'b0;
      chg_q   <= 1'b0;
      for (int i = 0; i < 4; i++) rpt_q[i] <= '0;
    end else begin
      hist_q  <= lvl;
      pend_q  <= pend_d;
      dwell_q <= dwell_d;
      ani_q   <= ani_d;
      cmp_q   <= cmp_d;
      auto_q  <= auto_d;
      chg_q   <= chg_d;
      for (int i = 0; i < 4; i++) rpt_q[i] <= rpt_d[i];
    end
  end

  assign animation_o   = ani_q;
  assign compare_o     = cmp_q;
  assign auto_o        = auto_q;
  assign ani_changed_o = chg_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// tb/tb_anim_sequencer.sv - directed self-checking bench for anim_sequencer
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_anim_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i, btn_auto_i;
  logic        frame_wrap_i;
  logic [3:0]  dwell_i;
  logic [5:0]  animation_o;
  logic [24:0] compare_o;
  logic        auto_o, ani_changed_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  anim_sequencer #(.REPEAT_VAL(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_next_i    (btn_next_i),
    .btn_prev_i    (btn_prev_i),
    .btn_fast_i    (btn_fast_i),
    .btn_slow_i    (btn_slow_i),
    .btn_auto_i    (btn_auto_i),
    .frame_wrap_i  (frame_wrap_i),
    .dwell_i       (dwell_i),
    .animation_o   (animation_o),
    .compare_o     (compare_o),
    .auto_o        (auto_o),
    .ani_changed_o (ani_changed_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse_btn(input int which);
    case (which)
      0: btn_next_i = 1'b1;
      1: btn_prev_i = 1'b1;
      2: btn_fast_i = 1'b1;
      3: btn_slow_i = 1'b1;
      default: btn_auto_i = 1'b1;
    endcase
    tick();
    {btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i, btn_auto_i} = '0;
    tick();
  endtask

  task automatic wrap_pulse();
    frame_wrap_i = 1'b1;
    tick();
    frame_wrap_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i, btn_auto_i} = '0;
    frame_wrap_i = 1'b0;
    dwell_i      = 4'd3;
    ticks(3);
    check("rst_ani",  32'(animation_o),   32'd0);
    check("rst_cmp",  32'(compare_o),     32'd10_000_000);
    check("rst_auto", 32'(auto_o),        32'd0);
    check("rst_chg",  32'(ani_changed_o), 32'd0);
    reset = 1'b0;
    tick();

    // three-cycle next press: one step, two cycles after the rise
    btn_next_i = 1'b1;
    tick();
    check("next_lat1", 32'(animation_o), 32'd0);
    tick();
    check("next_ani",  32'(animation_o),   32'd1);
    check("next_chg",  32'(ani_changed_o), 32'd1);
    tick();
    btn_next_i = 1'b0;
    check("next_chg_off", 32'(ani_changed_o), 32'd0);
    check("next_cmp",     32'(compare_o),     32'd10_000_000);
    tick();
    check("next_hold_ani", 32'(animation_o), 32'd1);

    pulse_btn(1);
    check("prev_to0", 32'(animation_o), 32'd0);
    pulse_btn(1);
    check("prev_wrap", 32'(animation_o), 32'd63);
    pulse_btn(0);
    check("next_wrap",     32'(animation_o),   32'd0);
    check("next_wrap_chg", 32'(ani_changed_o), 32'd1);

    // four simultaneous requests drain in priority order
    {btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i} = 4'b1111;
    tick();
    {btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i} = 4'b0000;
    tick();
    check("simul_next", 32'(animation_o), 32'd1);
    tick();
    check("simul_prev", 32'(animation_o), 32'd0);
    tick();
    check("simul_fast", 32'(compare_o), 32'd9_000_000);
    tick();
    check("simul_slow", 32'(compare_o), 32'd10_000_000);
    check("simul_ani",  32'(animation_o), 32'd0);

    for (int i = 0; i < 7; i++) pulse_btn(2);
    check("fast_to3M", 32'(compare_o), 32'd3_000_000);

    btn_fast_i = 1'b1;
    ticks(2);
    check("fast_first", 32'(compare_o), 32'd2_000_000);
    ticks(4);
    check("fast_before_rpt", 32'(compare_o), 32'd2_000_000);
    ticks(6);
    check("fast_rpt", 32'(compare_o), 32'd1_000_000);
    ticks(18);
    check("fast_sat", 32'(compare_o), 32'd1_000_000);
    btn_fast_i = 1'b0;
    tick();

    btn_slow_i = 1'b1;
    ticks(2);
    check("slow_first", 32'(compare_o), 32'd2_000_000);
    ticks(200);
    check("slow_sat", 32'(compare_o), 32'd19_000_000);
    btn_slow_i = 1'b0;
    tick();

    wrap_pulse();
    ticks(2);
    check("wrap_ignored", 32'(animation_o), 32'd0);

    pulse_btn(4);
    check("auto_on", 32'(auto_o), 32'd1);
    wrap_pulse();
    wrap_pulse();
    ticks(2);
    check("dwell_2of3", 32'(animation_o), 32'd0);
    wrap_pulse();
    tick();
    check("dwell_adv", 32'(animation_o),   32'd1);
    check("dwell_chg", 32'(ani_changed_o), 32'd1);
    wrap_pulse();
    wrap_pulse();
    ticks(2);
    check("dwell_2b", 32'(animation_o), 32'd1);
    pulse_btn(0);
    check("manual_next", 32'(animation_o), 32'd2);
    wrap_pulse();
    wrap_pulse();
    ticks(2);
    check("dwell_restart", 32'(animation_o), 32'd2);
    wrap_pulse();
    tick();
    check("dwell_adv2", 32'(animation_o), 32'd3);
    dwell_i = 4'd0;
    wrap_pulse();
    tick();
    check("dwell0_a", 32'(animation_o), 32'd4);
    wrap_pulse();
    tick();
    check("dwell0_b", 32'(animation_o), 32'd5);

    // reset with everything pending and autoplay on
    {btn_next_i, btn_prev_i, btn_fast_i, btn_slow_i} = 4'b1111;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_ani",  32'(animation_o),   32'd0);
    check("mid_rst_cmp",  32'(compare_o),     32'd10_000_000);
    check("mid_rst_auto", 32'(auto_o),        32'd0);
    check("mid_rst_chg",  32'(ani_changed_o), 32'd0);
    {btn_prev_i, btn_fast_i, btn_slow_i} = 3'b000;
    ticks(2);
    reset = 1'b0;
    tick();
    check("rel_lat", 32'(animation_o), 32'd0);
    tick();
    check("rel_step", 32'(animation_o),   32'd1);
    check("rel_chg",  32'(ani_changed_o), 32'd1);
    check("rel_cmp",  32'(compare_o),     32'd10_000_000);
    ticks(3);
    btn_next_i = 1'b0;
    ticks(3);
    check("rel_once", 32'(animation_o), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
